// File: rtl/image_buffer_fifo_if.sv
// Write/read handshake and status bus of the image buffer FIFO.
// The FIFO sits on the slave modport; producer and consumer logic sits on the master modport.
interface image_buffer_fifo_if #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2048
);
  logic [DATA_WIDTH-1:0]     din;
  logic                      wr_en;
  logic                      rd_en;
  logic [DATA_WIDTH-1:0]     dout;
  logic                      full;
  logic                      empty;
  logic                      prog_full;
  logic [$clog2(DEPTH):0]    data_count;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, empty, prog_full, data_count
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, empty, prog_full, data_count
  );
endinterface

// File: rtl/image_buffer_fifo.sv
// Circular-buffer FIFO with first-word-fall-through dout; new head is visible the edge after a write.
// Writes to a full FIFO are dropped unless a read pops on the same edge; reads of an empty FIFO are ignored.
module image_buffer_fifo #(
  parameter int DATA_WIDTH       = 128,
  parameter int DEPTH            = 2048,
  parameter int PROG_FULL_THRESH = 2000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               srst,
  image_buffer_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    rd_acc   = bus.rd_en && !empty;
    // A pop on the same edge frees a slot, so a full FIFO can still take a write.
    wr_acc   = bus.wr_en && (!full || rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (srst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; it is only visible through dout while non-empty.
  always_ff @(posedge clk) begin
    if (rst_n && !srst && wr_acc) mem_q[wr_ptr_q] <= bus.din;
  end

  assign bus.dout       = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.prog_full  = (count_q >= CW'(PROG_FULL_THRESH));
  assign bus.data_count = count_q;
endmodule

// File: tb/tb_image_buffer_fifo.sv
// Bench for image_buffer_fifo: directed scenarios plus random traffic against a queue reference model.
module tb_image_buffer_fifo;
  localparam int DW     = 128;
  localparam int DEPTH  = 2048;
  localparam int THRESH = 2000;
  localparam int CW     = $clog2(DEPTH) + 1;
  typedef logic [DW+CW+2:0] obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic srst;
  int   passed = 0;
  int   total  = 0;
  logic [DW-1:0] mq[$];

  image_buffer_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  image_buffer_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PROG_FULL_THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .srst(srst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t exp_obs();
    logic [DW-1:0] head;
    int n;
    n    = mq.size();
    head = (n > 0) ? mq[0] : '0;
    return {head, n == DEPTH, n == 0, n >= THRESH, CW'(n)};
  endfunction

  function automatic obs_t dut_obs();
    return {bus.dout, bus.full, bus.empty, bus.prog_full, bus.data_count};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock edge of stimulus; the model applies the FIFO rules to the pre-edge contents.
  task automatic step(input logic w, input logic r, input logic s, input logic [DW-1:0] d);
    bit rd_ok, wr_ok;
    bus.wr_en = w; bus.rd_en = r; srst = s; bus.din = d;
    @(posedge clk);
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
    if (s) mq.delete();
    else begin
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(d);
    end
    #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; srst = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; srst = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = '0;
    #2;
    total++; if ({bus.empty, bus.full, bus.prog_full} !== 3'b100)
      $display("FAIL reset_flags got=%b exp=100", {bus.empty, bus.full, bus.prog_full}); else passed++;
    total++; if (bus.data_count !== '0 || bus.dout !== '0)
      $display("FAIL reset_count_dout count=%0d dout=%h exp=0/0", bus.data_count, bus.dout); else passed++;
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; srst = 1'b1; bus.din = 128'h55;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.empty !== 1'b1 || bus.data_count !== '0)
      $display("FAIL reset_ignores_inputs empty=%b count=%0d exp=1/0", bus.empty, bus.data_count); else passed++;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; srst = 1'b0;
    rst_n = 1'b1;
    mq.delete();
  endtask

  task automatic test_order();
    step(1, 0, 0, 128'hA);
    total++; if (bus.dout !== 128'hA || bus.empty !== 1'b0)
      $display("FAIL order_first_fwft dout=%h empty=%b exp=a/0", bus.dout, bus.empty); else passed++;
    step(1, 0, 0, 128'hB);
    step(1, 0, 0, 128'hC);
    total++; if (bus.data_count !== CW'(3) || bus.dout !== 128'hA)
      $display("FAIL order_three count=%0d dout=%h exp=3/a", bus.data_count, bus.dout); else passed++;
    step(0, 1, 0, '0);
    total++; if (bus.dout !== 128'hB)
      $display("FAIL order_pop1 dout=%h exp=b", bus.dout); else passed++;
    step(0, 1, 0, '0);
    total++; if (bus.dout !== 128'hC)
      $display("FAIL order_pop2 dout=%h exp=c", bus.dout); else passed++;
    step(0, 1, 0, '0);
    total++; if (bus.empty !== 1'b1 || bus.dout !== '0)
      $display("FAIL order_pop3 empty=%b dout=%h exp=1/0", bus.empty, bus.dout); else passed++;
    step(0, 1, 1'b0, 128'hD);
    total++; if (bus.empty !== 1'b1 || bus.data_count !== '0)
      $display("FAIL empty_read_ignored empty=%b count=%0d exp=1/0", bus.empty, bus.data_count); else passed++;
  endtask

  task automatic test_prog_full();
    for (int i = 0; i < THRESH - 1; i++) step(1, 0, 0, DW'(i));
    total++; if (bus.prog_full !== 1'b0 || bus.data_count !== CW'(THRESH - 1))
      $display("FAIL pf_below pf=%b count=%0d exp=0/%0d", bus.prog_full, bus.data_count, THRESH - 1); else passed++;
    step(1, 0, 0, DW'(THRESH - 1));
    total++; if (bus.prog_full !== 1'b1 || bus.data_count !== CW'(THRESH))
      $display("FAIL pf_rise pf=%b count=%0d exp=1/%0d", bus.prog_full, bus.data_count, THRESH); else passed++;
    step(0, 1, 0, '0);
    total++; if (bus.prog_full !== 1'b0 || bus.data_count !== CW'(THRESH - 1))
      $display("FAIL pf_fall pf=%b count=%0d exp=0/%0d", bus.prog_full, bus.data_count, THRESH - 1); else passed++;
    step(0, 0, 1, '0);
    total++; if (bus.empty !== 1'b1 || bus.prog_full !== 1'b0)
      $display("FAIL pf_flush empty=%b pf=%b exp=1/0", bus.empty, bus.prog_full); else passed++;
  endtask

  task automatic test_full();
    int bad = 0;
    for (int i = 0; i <= DEPTH; i++) step(1, 0, 0, DW'(i));
    total++; if (bus.full !== 1'b1 || bus.data_count !== CW'(DEPTH) || bus.prog_full !== 1'b1)
      $display("FAIL full_level full=%b count=%0d pf=%b exp=1/%0d/1", bus.full, bus.data_count, bus.prog_full, DEPTH); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.dout !== DW'(i) && bad == 0) begin
        bad = 1;
        $display("FAIL full_drain_order idx=%0d dout=%h exp=%h", i, bus.dout, DW'(i));
      end
      step(0, 1, 0, '0);
    end
    total++; if (bad == 0) passed++;
    total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.dout !== '0)
      $display("FAIL full_drained empty=%b full=%b dout=%h exp=1/0/0", bus.empty, bus.full, bus.dout); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] w;
    for (int i = 0; i < 5; i++) step(1, 0, 0, rnd_word());
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, rnd_word());
      total++; if (bus.data_count !== CW'(5) || dut_obs() !== exp_obs())
        $display("FAIL simul_mid count=%0d dout=%h exp=5/%h", bus.data_count, bus.dout, exp_obs()[DW+CW+2 -: DW]); else passed++;
    end
    while (mq.size() < DEPTH) step(1, 0, 0, rnd_word());
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, rnd_word());
      total++; if (bus.full !== 1'b1 || dut_obs() !== exp_obs())
        $display("FAIL simul_full full=%b dout=%h exp=1/%h", bus.full, bus.dout, exp_obs()[DW+CW+2 -: DW]); else passed++;
    end
    step(0, 0, 1, '0);
    w = rnd_word();
    step(1, 1, 0, w);
    total++; if (bus.data_count !== CW'(1) || bus.dout !== w)
      $display("FAIL simul_empty count=%0d dout=%h exp=1/%h", bus.data_count, bus.dout, w); else passed++;
  endtask

  task automatic test_flush();
    logic [DW-1:0] w;
    step(0, 0, 1, '0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, rnd_word());
    step(1, 1, 1, 128'hDEAD);
    total++; if (bus.empty !== 1'b1 || bus.data_count !== '0 || bus.dout !== '0)
      $display("FAIL flush empty=%b count=%0d dout=%h exp=1/0/0", bus.empty, bus.data_count, bus.dout); else passed++;
    w = rnd_word();
    step(1, 0, 0, w);
    total++; if (bus.dout !== w || bus.data_count !== CW'(1))
      $display("FAIL flush_after dout=%h count=%0d exp=%h/1", bus.dout, bus.data_count, w); else passed++;
  endtask

  task automatic test_reset_midstream();
    step(0, 0, 1, '0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, rnd_word());
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.empty, bus.full, bus.prog_full} !== 3'b100 || bus.data_count !== '0 || bus.dout !== '0)
      $display("FAIL reset_midstream flags=%b count=%0d dout=%h exp=100/0/0",
               {bus.empty, bus.full, bus.prog_full}, bus.data_count, bus.dout); else passed++;
    mq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int wp, rp, bad;
    bad = 0;
    for (int ph = 0; ph < 3; ph++) begin
      wp = (ph == 0) ? 85 : (ph == 1) ? 25 : 55;
      rp = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
      for (int i = 0; i < 1000; i++) begin
        step($urandom_range(99) < wp, $urandom_range(99) < rp, $urandom_range(499) == 0, rnd_word());
        total++;
        if (dut_obs() !== exp_obs()) begin
          if (bad < 10) $display("FAIL random ph=%0d cyc=%0d got=%h exp=%h", ph, i, dut_obs(), exp_obs());
          bad++;
        end else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_prog_full();
    test_full();
    test_simultaneous();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
